// File: rtl/selector_pkg.sv
// selector_n shared definitions: state encoding and mode constants.
// Round-robin support is enabled by defining SEL_RR_EN.
package selector_pkg;

   typedef enum logic [1:0] {
      SEL_EMPTY = 2'd0,
      SEL_BUSY  = 2'd1,
      SEL_FULL  = 2'd2
   } sel_state_e;

   localparam logic SEL_MODE_FIXED = 1'b0;
   localparam logic SEL_MODE_RR    = 1'b1;

endpackage

// File: rtl/selector_n_rr_grant.sv
// Round-robin grant search for selector_n, built only when SEL_RR_EN is set.
// Picks the first valid channel starting at Ptr and wrapping around.
`ifdef SEL_RR_EN
module rr_grant #(
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    InValid,
   input  logic [SELW-1:0] Ptr,
   output logic [SELW-1:0] grant,
   output logic            grant_valid
);

   int unsigned idx;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(Ptr) + k) % N;
         if (!grant_valid && InValid[idx]) begin
            grant       = SELW'(idx);
            grant_valid = 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/selector_n.sv
// N-way registered selector with valid/ready, output register plus skid.
// Define SEL_RR_EN to add the Mode port and round-robin arbitration.
module selector_n
   import selector_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [N*WIDTH-1:0] In,
   input  logic [N-1:0]       InValid,
   output logic [N-1:0]       InReady,
   input  logic [SELW-1:0]    Sel,
`ifdef SEL_RR_EN
   input  logic               Mode,
`endif
   output logic [WIDTH-1:0]   Out,
   output logic [SELW-1:0]    OutSel,
   output logic               OutValid,
   input  logic               OutReady
);

   localparam logic [SELW:0] NCH = (SELW+1)'(N);

   sel_state_e state, state_nxt;

   logic             accept_en;
   logic [WIDTH-1:0] skid_data;
   logic [SELW-1:0]  skid_sel;
   logic [SELW-1:0]  g;
   logic             g_valid;
   logic             fixed_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_valid_g;
   logic             in_fire;
   logic             out_fire;
   logic             load_out;
   logic             load_skid;
   logic             skid_to_out;

   assign fixed_valid = {1'b0, Sel} < NCH;

`ifdef SEL_RR_EN
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] rr_g;
   logic            rr_v;

   rr_grant #(
      .N    (N),
      .SELW (SELW)
   ) u_rr (
      .InValid     (InValid),
      .Ptr         (ptr),
      .grant       (rr_g),
      .grant_valid (rr_v)
   );

   assign g       = (Mode == SEL_MODE_RR) ? rr_g : Sel;
   assign g_valid = (Mode == SEL_MODE_RR) ? rr_v : fixed_valid;

   always_ff @(posedge CLK) begin
      if (Reset)
         ptr <= '0;
      else if (in_fire)
         ptr <= (g == SELW'(N-1)) ? '0 : g + 1'b1;
   end
`else
   assign g       = Sel;
   assign g_valid = fixed_valid;
`endif

   // Ready follows the grant only; it never looks at OutReady.
   always_comb begin
      in_data    = '0;
      in_valid_g = 1'b0;
      InReady    = '0;
      for (int i = 0; i < N; i++) begin
         if (g_valid && g == SELW'(i)) begin
            in_data    = In[i*WIDTH +: WIDTH];
            in_valid_g = InValid[i];
            InReady[i] = accept_en && !Reset;
         end
      end
   end

   assign in_fire  = in_valid_g && accept_en && !Reset;
   assign out_fire = OutValid && OutReady;

   always_comb begin
      state_nxt   = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      unique case (state)
         SEL_EMPTY: begin
            if (in_fire) begin
               load_out  = 1'b1;
               state_nxt = SEL_BUSY;
            end
         end
         SEL_BUSY: begin
            if (in_fire && out_fire) begin
               load_out = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_nxt = SEL_FULL;
            end else if (out_fire) begin
               state_nxt = SEL_EMPTY;
            end
         end
         SEL_FULL: begin
            if (out_fire) begin
               skid_to_out = 1'b1;
               state_nxt   = SEL_BUSY;
            end
         end
         default: state_nxt = SEL_EMPTY;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state     <= SEL_EMPTY;
         accept_en <= 1'b1;
         OutValid  <= 1'b0;
         Out       <= '0;
         OutSel    <= '0;
         skid_data <= '0;
         skid_sel  <= '0;
      end else begin
         state     <= state_nxt;
         accept_en <= (state_nxt != SEL_FULL);
         OutValid  <= (state_nxt != SEL_EMPTY);
         if (load_out) begin
            Out    <= in_data;
            OutSel <= g;
         end else if (skid_to_out) begin
            Out    <= skid_data;
            OutSel <= skid_sel;
         end
         if (load_skid) begin
            skid_data <= in_data;
            skid_sel  <= g;
         end
      end
   end

endmodule

// File: tb/tb_selector_n.sv
// Self-checking bench for selector_n: vector table, directed sequences,
// and random traffic against a two-entry FIFO model (SEL_RR_EN optional).
module tb_selector_n;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int SW = 2;
   localparam int W3 = 8;
   localparam int N3 = 3;

   logic          CLK = 1'b0;
   logic          Reset = 1'b0;
   logic [N*W-1:0] In = '0;
   logic [N-1:0]  InValid = '0;
   logic [N-1:0]  InReady;
   logic [SW-1:0] Sel = '0;
   logic          Mode = 1'b0;
   logic [W-1:0]  Out;
   logic [SW-1:0] OutSel;
   logic          OutValid;
   logic          OutReady = 1'b0;

   logic [N3*W3-1:0] In3 = '0;
   logic [N3-1:0]    InValid3 = '0;
   logic [N3-1:0]    InReady3;
   logic [1:0]       Sel3 = '0;
   logic [W3-1:0]    Out3;
   logic [1:0]       OutSel3;
   logic             OutValid3;
   logic             OutReady3 = 1'b0;

   always #5 CLK = ~CLK;

   selector_n #(.WIDTH(W), .N(N)) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .In       (In),
      .InValid  (InValid),
      .InReady  (InReady),
      .Sel      (Sel),
`ifdef SEL_RR_EN
      .Mode     (Mode),
`endif
      .Out      (Out),
      .OutSel   (OutSel),
      .OutValid (OutValid),
      .OutReady (OutReady)
   );

   selector_n #(.WIDTH(W3), .N(N3)) dut3 (
      .CLK      (CLK),
      .Reset    (Reset),
      .In       (In3),
      .InValid  (InValid3),
      .InReady  (InReady3),
      .Sel      (Sel3),
`ifdef SEL_RR_EN
      .Mode     (1'b0),
`endif
      .Out      (Out3),
      .OutSel   (OutSel3),
      .OutValid (OutValid3),
      .OutReady (OutReady3)
   );

   int unsigned npass = 0;
   int unsigned ntotal = 0;

   logic [W+SW-1:0] q[$];
   int              ptr = 0;
   bit              armed = 0;
   logic [W-1:0]    got_d[$];
   logic [SW-1:0]   got_s[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic void model_grant(output int g, output bit gv);
      g  = 0;
      gv = 0;
      if (Mode) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (!gv && InValid[idx]) begin
               g  = idx;
               gv = 1;
            end
         end
      end else begin
         g  = int'(Sel);
         gv = g < N;
      end
   endfunction

   task automatic fall();
      int g;
      bit gv;
      logic [N-1:0] er;
      @(negedge CLK);
      if (armed) begin
         model_grant(g, gv);
         er = '0;
         if (!Reset && q.size() < 2 && gv) er[g] = 1'b1;
         chk("inready", InReady, er);
         chk("outvalid", OutValid, q.size() > 0);
         if (q.size() > 0) begin
            chk("out", Out, q[0][W+SW-1:SW]);
            chk("outsel", OutSel, q[0][SW-1:0]);
         end
      end
      if (OutValid === 1'b1 && OutReady) begin
         got_d.push_back(Out);
         got_s.push_back(OutSel);
      end
   endtask

   task automatic rise();
      int g;
      bit gv;
      bit rdy;
      bit do_in;
      bit do_out;
      @(posedge CLK);
      if (Reset) begin
         q.delete();
         ptr   = 0;
         armed = 1;
      end else begin
         model_grant(g, gv);
         rdy    = gv && q.size() < 2;
         do_in  = rdy && InValid[g];
         do_out = q.size() > 0 && OutReady;
         if (do_out) void'(q.pop_front());
         if (do_in) begin
            q.push_back({In[g*W +: W], SW'(g)});
            ptr = (g + 1) % N;
         end
      end
      #1;
   endtask

   task automatic tick();
      fall();
      rise();
   endtask

   task automatic do_reset();
      Reset   = 1'b1;
      InValid = '1;
      tick();
      tick();
      chk("rst_out", Out, 0);
      chk("rst_outsel", OutSel, 0);
      chk("rst_outvalid", OutValid, 0);
      chk("rst_inready", InReady, 0);
      chk("rst_inready3", InReady3, 0);
      Reset   = 1'b0;
      InValid = '0;
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic [31:0] data;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_vld;
      logic [31:0] e_out;
      logic [1:0]  e_sel;
   } vec_t;

   vec_t vt[9];

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] sent[$];
      bit           c_sent;

      vt[0] = '{2'd2, 4'b0100, 32'hDEAD_BEEF, 1'b1, 4'b0100, 1'b0, 32'h0, 2'd0};
      vt[1] = '{2'd0, 4'b0000, 32'h0, 1'b1, 4'b0001, 1'b1, 32'hDEAD_BEEF, 2'd2};
      vt[2] = '{2'd3, 4'b1000, 32'h11, 1'b0, 4'b1000, 1'b0, 32'h0, 2'd0};
      vt[3] = '{2'd3, 4'b1000, 32'h22, 1'b0, 4'b1000, 1'b1, 32'h11, 2'd3};
      vt[4] = '{2'd3, 4'b1000, 32'h33, 1'b0, 4'b0000, 1'b1, 32'h11, 2'd3};
      vt[5] = '{2'd3, 4'b1000, 32'h33, 1'b1, 4'b0000, 1'b1, 32'h11, 2'd3};
      vt[6] = '{2'd3, 4'b1000, 32'h33, 1'b1, 4'b1000, 1'b1, 32'h22, 2'd3};
      vt[7] = '{2'd3, 4'b0000, 32'h0, 1'b1, 4'b1000, 1'b1, 32'h33, 2'd3};
      vt[8] = '{2'd3, 4'b0000, 32'h0, 1'b1, 4'b1000, 1'b0, 32'h0, 2'd0};

      #1;
      do_reset();

      for (int i = 0; i < 9; i++) begin
         Sel      = vt[i].sel;
         InValid  = vt[i].vld;
         In       = {N{~vt[i].data}};
         In[int'(vt[i].sel)*W +: W] = vt[i].data;
         OutReady = vt[i].ordy;
         fall();
         chk($sformatf("vec%0d_rdy", i), InReady, vt[i].e_rdy);
         chk($sformatf("vec%0d_vld", i), OutValid, vt[i].e_vld);
         if (vt[i].e_vld) begin
            chk($sformatf("vec%0d_out", i), Out, vt[i].e_out);
            chk($sformatf("vec%0d_sel", i), OutSel, vt[i].e_sel);
         end
         rise();
      end

      // back-pressure: A, B, C on channel 1
      got_d.delete();
      got_s.delete();
      Sel = 2'd1;
      OutReady = 1'b0;
      InValid = 4'b0010;
      In[W +: W] = 32'hA0A0_0001;
      tick();
      In[W +: W] = 32'hB0B0_0002;
      tick();
      chk("bp_rdy_low", InReady, 0);
      In[W +: W] = 32'hC0C0_0003;
      tick();
      chk("bp_rdy_still_low", InReady, 0);
      OutReady = 1'b1;
      c_sent = 0;
      for (int k = 0; k < 6; k++) begin
         if (c_sent) InValid = '0;
         fall();
         if (InReady[1] && InValid[1]) c_sent = 1;
         rise();
      end
      chk("bp_count", got_d.size(), 3);
      if (got_d.size() == 3) begin
         chk("bp_a", got_d[0], 32'hA0A0_0001);
         chk("bp_b", got_d[1], 32'hB0B0_0002);
         chk("bp_c", got_d[2], 32'hC0C0_0003);
      end

      // streaming on channel 0
      got_d.delete();
      got_s.delete();
      Sel = 2'd0;
      OutReady = 1'b1;
      for (int k = 0; k < 16; k++) begin
         a = $urandom;
         sent.push_back(a);
         In[0 +: W] = a;
         InValid = 4'b0001;
         tick();
      end
      InValid = '0;
      tick();
      chk("stream_count", got_d.size(), 16);
      for (int k = 0; k < 16 && k < got_d.size(); k++)
         chk($sformatf("stream%0d", k), got_d[k], sent[k]);

      // out-of-range select on the 3-channel instance
      Sel3 = 2'd3;
      InValid3 = '1;
      In3 = {8'h5C, 8'h5B, 8'h5A};
      OutReady3 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("oor_rdy", InReady3, 0);
         chk("oor_vld", OutValid3, 0);
      end
      Sel3 = 2'd2;
      #1;
      chk("n3_rdy", InReady3, 3'b100);
      tick();
      chk("n3_vld", OutValid3, 1);
      chk("n3_out", Out3, 8'h5C);
      chk("n3_sel", OutSel3, 2);
      InValid3 = '0;

`ifdef SEL_RR_EN
      do_reset();
      Mode = 1'b1;
      OutReady = 1'b1;
      for (int i = 0; i < N; i++) In[i*W +: W] = 32'h100 + i;
      got_s.delete();
      InValid = 4'b1111;
      for (int k = 0; k < 6; k++) tick();
      InValid = '0;
      tick();
      chk("rr_all_n", got_s.size() >= 5, 1);
      for (int k = 0; k < 5 && k < got_s.size(); k++)
         chk($sformatf("rr_all%0d", k), got_s[k], k % 4);
      do_reset();
      Mode = 1'b1;
      got_s.delete();
      InValid = 4'b1010;
      for (int k = 0; k < 4; k++) tick();
      InValid = '0;
      tick();
      chk("rr_13_n", got_s.size() >= 3, 1);
      if (got_s.size() >= 3) begin
         chk("rr_13_0", got_s[0], 1);
         chk("rr_13_1", got_s[1], 3);
         chk("rr_13_2", got_s[2], 1);
      end
      Mode = 1'b0;
`endif

      // random traffic against the model
      for (int k = 0; k < 400; k++) begin
         Reset = ($urandom_range(0, 63) == 0);
         Sel = SW'($urandom_range(0, 3));
         InValid = N'($urandom);
         for (int i = 0; i < N; i++) In[i*W +: W] = $urandom;
         OutReady = ($urandom_range(0, 3) != 0);
`ifdef SEL_RR_EN
         Mode = ($urandom_range(0, 1) == 1);
`endif
         tick();
      end
      Reset = 1'b0;
      InValid = '0;
      OutReady = 1'b1;
      tick();
      tick();

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/selector_n.md
# selector_n

Parametrised N-way, WIDTH-bit registered selector with a valid/ready handshake on every input channel and on the output. It replaces fixed 2-input combinational selection wherever the multi-cycle datapath needs a pipelined, back-pressure-aware choice between several producers, such as operand sources or write-back sources. It has one output register stage plus a one-entry skid buffer, so it sustains one transfer per cycle with fully registered ready. An optional round-robin mode arbitrates among valid channels instead of obeying an explicit select.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- N, 4, channel count, 2..16
- SELW, $clog2(N) (local, derived), select/index width

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high reset
- In  in  N*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- InValid  in  N  per-channel valid
- InReady  out  N  per-channel ready; at most one bit set per cycle
- Sel  in  SELW  channel select in fixed mode; values >= N select nothing
- Mode  in  1  0 = fixed select, 1 = round-robin (present only with SEL_RR_EN)
- Out  out  WIDTH  selected data, registered
- OutSel  out  SELW  index of the channel that produced Out
- OutValid  out  1  Out/OutSel valid
- OutReady  in  1  downstream accepts when OutValid && OutReady

## Operation
- Internal state:
  - EMPTY: no data held
  - BUSY: output register full, skid empty
  - FULL: output register and skid full
- AcceptEn: registered; 1 in EMPTY and BUSY, 0 in FULL.
- Grant g in fixed mode: g = Sel.
- Grant g in round-robin mode: first i with InValid[i] set, searching Ptr, Ptr+1, … N-1, then 0 … Ptr-1. With no valid channel there is no grant.
- InReady[g] = AcceptEn && !Reset. All other InReady bits are 0.
- Input transfer: InValid[g] && InReady[g]. It captures {In[g], g}.
- Output transfer: OutValid && OutReady.
- EMPTY + in: load output register → BUSY.
- BUSY + in, no out: load skid → FULL.
- BUSY + in + out: load output register directly → BUSY.
- BUSY + out only: → EMPTY.
- FULL + out: move skid to output register → BUSY. No input is accepted, because AcceptEn = 0.
- Ptr (round-robin only) updates on an input transfer to g+1, wrapping from N-1 to 0. It is unchanged otherwise.
- Out and OutSel hold their values while OutValid && !OutReady.
- Sel or Mode changes take effect in the same cycle. Captured data is never altered.
- Reset values:
  - state EMPTY, OutValid 0, Out 0, OutSel 0, Ptr 0, skid contents 0
  - InReady all 0 while Reset is high
- Reset mid-operation: buffered data is discarded and no transfer occurs in that cycle.

## Timing
- Latency: 1 cycle from input transfer to OutValid (EMPTY/BUSY path).
- Throughput: 1 transfer/cycle while OutReady is held high.
- InReady depends combinationally on Sel/InValid (grant mux) and the registered AcceptEn. It never depends on OutReady.
- OutValid, Out and OutSel are driven only from flops.
- After FULL, at most 1 cycle of InReady low once OutReady returns.

## Configuration
- SEL_RR_EN defined:
  - the Mode port exists
  - the round-robin grant logic and Ptr register are built
- SEL_RR_EN undefined:
  - no Mode port
  - fixed select only
  - no Ptr register
  - behaviour is identical to Mode = 0

## Structure
- Shared package selector_pkg holds:
  - state encoding constants SEL_EMPTY = 2'd0, SEL_BUSY = 2'd1, SEL_FULL = 2'd2
  - mode constants SEL_MODE_FIXED = 1'b0, SEL_MODE_RR = 1'b1
- Sub-module rr_grant (N, SELW) is compiled only under SEL_RR_EN.
  - Inputs: InValid, Ptr.
  - Outputs: grant index and grant-valid.
  - Purely combinational.

## Test plan
- Reset: hold Reset 2 cycles with InValid = all ones → InReady = 0, OutValid = 0, Out = 0. Release → InReady[Sel] = 1 the next cycle.
- Fixed select, N=4, WIDTH=32:
  - Stimulus: Sel=2, In[2]=32'hDEAD_BEEF valid, OutReady=1.
  - Response: Out=32'hDEAD_BEEF, OutSel=2, OutValid=1 one cycle later.
  - Other channels never see InReady.
- Back-pressure:
  - Stimulus: OutReady=0, 3 back-to-back inputs A, B, C on channel 1.
  - Response: A in the output register, B in skid, InReady low from the cycle after B.
  - Stimulus: raise OutReady.
  - Response: output order A, B, C with no loss or duplication.
- Streaming: OutReady=1 and continuous valid for 16 cycles → 16 outputs in 16 cycles, in input order.
- Sel out of range: Sel = N with all channels valid (N not a power of two) → no InReady, no transfer.
- Round-robin (SEL_RR_EN, Mode=1):
  - Stimulus: all 4 channels valid continuously, OutReady=1.
  - Response: OutSel sequence 0,1,2,3,0.
  - Stimulus: only channels 1 and 3 valid.
  - Response: alternates 1,3,1.
